// File: rtl/mdu_seq_pkg.sv
// Shared MDU opcodes, FSM state encoding and the multi-cycle decode.
// Opcode values must match the instruction decoder's MDU_* field.
package mdu_seq_pkg;

    localparam int OP_W = 5;

    localparam logic [OP_W-1:0] MDU_err   = 5'd0;
    localparam logic [OP_W-1:0] MDU_mult  = 5'd1;
    localparam logic [OP_W-1:0] MDU_multu = 5'd2;
    localparam logic [OP_W-1:0] MDU_div   = 5'd3;
    localparam logic [OP_W-1:0] MDU_divu  = 5'd4;
    localparam logic [OP_W-1:0] MDU_mfhi  = 5'd5;
    localparam logic [OP_W-1:0] MDU_mflo  = 5'd6;
    localparam logic [OP_W-1:0] MDU_mthi  = 5'd7;
    localparam logic [OP_W-1:0] MDU_mtlo  = 5'd8;
    localparam logic [OP_W-1:0] MDU_madd  = 5'd9;
    localparam logic [OP_W-1:0] MDU_maddu = 5'd10;
    localparam logic [OP_W-1:0] MDU_msub  = 5'd11;
    localparam logic [OP_W-1:0] MDU_msubu = 5'd12;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mdu_state_t;

    function automatic logic is_multicycle(input logic [OP_W-1:0] op);
        case (op)
            MDU_mult, MDU_multu, MDU_madd, MDU_maddu,
            MDU_msub, MDU_msubu, MDU_div, MDU_divu: is_multicycle = 1'b1;
            default:                                is_multicycle = 1'b0;
        endcase
    endfunction

    function automatic logic is_div(input logic [OP_W-1:0] op);
        is_div = (op == MDU_div) || (op == MDU_divu);
    endfunction

endpackage

// File: rtl/mdu_seq_arith.sv
// Combinational {HI,LO} result for every multi-cycle MDU op, divide special cases included.
// Latency: 0 cycles (pure logic). Backpressure: none, sampled by the sequencer only at launch.
module mdu_arith
    import mdu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [OP_W-1:0]    op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   hi,
    input  logic [WIDTH-1:0]   lo,
    output logic [2*WIDTH-1:0] result
);

    logic               sgn;
    logic [2*WIDTH-1:0] ext_a;
    logic [2*WIDTH-1:0] ext_b;
    logic [2*WIDTH-1:0] prod;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH-1:0]   divisor;
    logic [WIDTH-1:0]   q_mag;
    logic [WIDTH-1:0]   r_mag;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;

    assign sgn = (op == MDU_mult) || (op == MDU_madd) || (op == MDU_msub) || (op == MDU_div);

    // Sign/zero extension to 2*WIDTH makes a truncated 2*WIDTH product exact for both signednesses.
    assign ext_a = {{WIDTH{sgn & a[WIDTH-1]}}, a};
    assign ext_b = {{WIDTH{sgn & b[WIDTH-1]}}, b};
    assign prod  = ext_a * ext_b;

    // Magnitude division: most-negative / -1 falls out as quotient 0x80..0, remainder 0.
    assign a_neg   = sgn & a[WIDTH-1];
    assign b_neg   = sgn & b[WIDTH-1];
    assign mag_a   = a_neg ? (~a + 1'b1) : a;
    assign mag_b   = b_neg ? (~b + 1'b1) : b;
    assign divisor = (mag_b == '0) ? WIDTH'(1) : mag_b;
    assign q_mag   = mag_a / divisor;
    assign r_mag   = mag_a % divisor;
    assign quot    = (a_neg ^ b_neg) ? (~q_mag + 1'b1) : q_mag;
    assign rem     = a_neg ? (~r_mag + 1'b1) : r_mag;

    always_comb begin
        result = {hi, lo};
        case (op)
            MDU_mult, MDU_multu:  result = prod;
            MDU_madd, MDU_maddu:  result = {hi, lo} + prod;
            MDU_msub, MDU_msubu:  result = {hi, lo} - prod;
            MDU_div, MDU_divu:    result = (b == '0) ? {hi, lo} : {rem, quot};
            default:              result = {hi, lo};
        endcase
    end

endmodule

// File: rtl/mdu_seq.sv
// Sequential multiply/divide unit holding HI/LO; mult-class and div ops commit after a fixed latency.
// Latency: MULT_CYCLES / DIV_CYCLES busy cycles, mthi/mtlo one cycle, mfhi/mflo combinational.
// Backpressure: stall_req holds D while busy or launching; start while busy is dropped.
module mdu_seq
    import mdu_seq_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [OP_W-1:0]  op,
    input  logic             flush,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             stall_req,
    output logic [WIDTH-1:0] rdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    mdu_state_t         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] pend_q, pend_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [2*WIDTH-1:0] arith_res;
    logic               launch;

    mdu_arith #(.WIDTH(WIDTH)) u_arith (
        .op     (op),
        .a      (a),
        .b      (b),
        .hi     (hi_q),
        .lo     (lo_q),
        .result (arith_res)
    );

    assign busy      = (state_q == RUN);
    assign launch    = start & ~flush & (state_q == IDLE);
    assign stall_req = busy | (start & is_multicycle(op));
    assign hi        = hi_q;
    assign lo        = lo_q;

    always_comb begin
        rdata = '0;
        if (op == MDU_mfhi)
            rdata = hi_q;
        else if (op == MDU_mflo)
            rdata = lo_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (launch) begin
                    if (is_multicycle(op)) begin
                        pend_d  = arith_res;
                        cnt_d   = is_div(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        state_d = RUN;
                    end else if (op == MDU_mthi) begin
                        hi_d = a;
                    end else if (op == MDU_mtlo) begin
                        lo_d = a;
                    end
                end
            end
            RUN: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    {hi_d, lo_d} = pend_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// Directed self-checking bench for mdu_seq with hand-computed HI/LO and busy-length expectations.
module tb_mdu_seq;
    import mdu_seq_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  op;
    logic        flush;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        stall_req;
    logic [31:0] rdata;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_assert = 0;
    int n_fail   = 0;
    int nb;

    mdu_seq #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .flush     (flush),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .stall_req (stall_req),
        .rdata     (rdata),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one op for a single cycle; returns in the cycle after the launch.
    task automatic issue(input logic [4:0] o, input logic [31:0] va, input logic [31:0] vb);
        start = 1'b1;
        op    = o;
        a     = va;
        b     = vb;
        step();
        start = 1'b0;
        op    = MDU_err;
    endtask

    // Counts cycles with busy high from the current cycle, bounded.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 50) begin
            n++;
            step();
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = MDU_err;
        flush = 1'b0;
        a     = '0;
        b     = '0;
        #12;
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        reset = 1'b0;
        step();

        // mult: -2 * 3
        start = 1'b1; op = MDU_mult; a = 32'hFFFF_FFFE; b = 32'd3;
        #1;
        chk("mult_stall_launch", {31'b0, stall_req}, 32'd1);
        chk("mult_busy_launch", {31'b0, busy}, 32'd0);
        step();
        start = 1'b0; op = MDU_err;
        chk("mult_stall_run", {31'b0, stall_req}, 32'd1);
        wait_idle(nb);
        chk("mult_busy_len", nb, 32'd5);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFA);
        chk("mult_stall_done", {31'b0, stall_req}, 32'd0);

        // multu back-to-back with the same operands
        issue(MDU_multu, 32'hFFFF_FFFE, 32'd3);
        wait_idle(nb);
        chk("multu_busy_len", nb, 32'd5);
        chk("multu_hi", hi, 32'h0000_0002);
        chk("multu_lo", lo, 32'hFFFF_FFFA);

        // div -7 / 2
        issue(MDU_div, 32'hFFFF_FFF9, 32'd2);
        wait_idle(nb);
        chk("div_busy_len", nb, 32'd10);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);

        // divu by zero leaves HI/LO alone
        issue(MDU_divu, 32'd7, 32'd0);
        wait_idle(nb);
        chk("divz_busy_len", nb, 32'd10);
        chk("divz_lo", lo, 32'hFFFF_FFFD);
        chk("divz_hi", hi, 32'hFFFF_FFFF);

        // signed overflow divide
        issue(MDU_div, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(nb);
        chk("divov_lo", lo, 32'h8000_0000);
        chk("divov_hi", hi, 32'h0000_0000);

        // mthi / mtlo / madd / msub
        issue(MDU_mthi, 32'd0, 32'd0);
        chk("mthi_busy", {31'b0, busy}, 32'd0);
        chk("mthi_hi", hi, 32'd0);
        issue(MDU_mtlo, 32'd5, 32'd0);
        chk("mtlo_lo", lo, 32'd5);
        issue(MDU_madd, 32'd2, 32'd3);
        wait_idle(nb);
        chk("madd_busy_len", nb, 32'd5);
        chk("madd_lo", lo, 32'd11);
        chk("madd_hi", hi, 32'd0);
        issue(MDU_msub, 32'd4, 32'd3);
        wait_idle(nb);
        chk("msub_lo", lo, 32'hFFFF_FFFF);
        chk("msub_hi", hi, 32'hFFFF_FFFF);

        // start + flush in the same cycle
        start = 1'b1; op = MDU_mult; a = 32'd5; b = 32'd5; flush = 1'b1;
        #1;
        chk("flush_stall", {31'b0, stall_req}, 32'd1);
        step();
        start = 1'b0; flush = 1'b0; op = MDU_err;
        chk("flush_busy", {31'b0, busy}, 32'd0);
        chk("flush_lo", lo, 32'hFFFF_FFFF);
        chk("flush_hi", hi, 32'hFFFF_FFFF);

        // mtlo while busy is dropped
        issue(MDU_multu, 32'd2, 32'd3);
        chk("mtlo_busy_running", {31'b0, busy}, 32'd1);
        issue(MDU_mtlo, 32'h0000_DEAD, 32'd0);
        wait_idle(nb);
        chk("mtlo_busy_len", nb + 1, 32'd5);
        chk("mtlo_busy_lo", lo, 32'd6);
        chk("mtlo_busy_hi", hi, 32'd0);

        // rdata mux
        op = MDU_mflo; #1;
        chk("rdata_mflo", rdata, 32'd6);
        op = MDU_mfhi; #1;
        chk("rdata_mfhi", rdata, 32'd0);
        op = MDU_mult; #1;
        chk("rdata_other", rdata, 32'd0);
        op = MDU_err;

        // unknown opcode does nothing
        issue(5'd31, 32'd9, 32'd9);
        chk("unk_busy", {31'b0, busy}, 32'd0);
        chk("unk_lo", lo, 32'd6);

        // reset in the middle of a divide
        issue(MDU_div, 32'd100, 32'd7);
        step();
        step();
        chk("rst_mid_busy_before", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_mid_busy", {31'b0, busy}, 32'd0);
        chk("rst_mid_hi", hi, 32'd0);
        chk("rst_mid_lo", lo, 32'd0);
        #1;
        reset = 1'b0;
        step();

        // mult right after reset
        issue(MDU_mult, 32'd7, 32'd6);
        wait_idle(nb);
        chk("post_rst_busy_len", nb, 32'd5);
        chk("post_rst_lo", lo, 32'd42);
        chk("post_rst_hi", hi, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
